// File: rtl/gate_response_checker_pkg.sv
//------------------------------------------------------------------------------
// Module : hack_test_pkg
// Brief  : Shared FSM encodings and gate truth-table constants for the
//          gate response checker.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hack_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/gate_response_checker_if.sv
//------------------------------------------------------------------------------
// Module : gate_response_checker_if
// Brief  : Sample handshake bundle between a gate-under-test monitor and the
//          response checker.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gate_response_checker_if #(
    parameter int NUM_IN = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [NUM_IN-1:0] in_vec;
    logic              in_out;

    modport master (
        output in_valid,
        output in_vec,
        output in_out,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  in_out,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/gate_response_checker_cov_tracker.sv
//------------------------------------------------------------------------------
// Module : gate_cov_tracker
// Brief  : Input-vector coverage bitmap; all_covered already includes the set
//          requested this cycle so the caller can finish on that edge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_cov_tracker #(
    parameter int NUM_IN = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clr,
    input  wire logic              set_en,
    input  wire logic [NUM_IN-1:0] set_idx,
    output logic                   all_covered
);
    localparam int c_DEPTH = 1 << NUM_IN;

    logic [c_DEPTH-1:0] r_bitmap;
    logic [c_DEPTH-1:0] w_set_mask;

    always_comb begin
        w_set_mask = '0;
        if (set_en) begin
            w_set_mask[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitmap <= '0;
        end else if (clr) begin
            r_bitmap <= '0;
        end else begin
            r_bitmap <= r_bitmap | w_set_mask;
        end
    end

    assign all_covered = &(r_bitmap | w_set_mask);

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
//------------------------------------------------------------------------------
// Module : gate_response_checker
// Brief  : Checks observed gate outputs against a truth table until every
//          input vector has been seen. Optional idle timeout is compiled in
//          with GATE_CHECK_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_response_checker
    import hack_test_pkg::*;
#(
    parameter int                     NUM_IN  = 2,
    parameter logic [(1<<NUM_IN)-1:0] TRUTH   = TRUTH_OR,
    parameter int                     TIMEOUT = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    gate_response_checker_if.slave  smp,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [NUM_IN-1:0]       first_fail,
    output logic                    timeout
);
    state_t            r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [7:0]        r_err_count;
    logic [NUM_IN-1:0] r_first_fail;

    logic       w_hs;
    logic       w_mismatch;
    logic       w_start_run;
    logic       w_all_cov;
    logic [7:0] w_err_next;

    assign w_hs        = smp.in_valid & r_in_ready;
    assign w_mismatch  = w_hs & (smp.in_out != TRUTH[smp.in_vec]);
    assign w_start_run = start & (r_state != ST_CHECK);
    assign w_err_next  = (w_mismatch && (r_err_count != ERR_MAX)) ?
                         (r_err_count + 8'd1) : r_err_count;

    gate_cov_tracker #(
        .NUM_IN (NUM_IN)
    ) u_cov (
        .clk         (clk),
        .reset       (reset),
        .clr         (w_start_run),
        .set_en      (w_hs),
        .set_idx     (smp.in_vec),
        .all_covered (w_all_cov)
    );

`ifdef GATE_CHECK_TIMEOUT_EN
    localparam int                c_CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_idle_cnt;
    logic               r_timeout;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
`ifdef GATE_CHECK_TIMEOUT_EN
            r_idle_cnt   <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_CHECK;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
`ifdef GATE_CHECK_TIMEOUT_EN
                        r_idle_cnt   <= '0;
                        r_timeout    <= 1'b0;
`endif
                    end
                end
                ST_CHECK: begin
                    if (w_hs) begin
                        r_err_count <= w_err_next;
                        // A zero count means no mismatch yet this run (it saturates, never wraps).
                        if (w_mismatch && (r_err_count == 8'd0)) begin
                            r_first_fail <= smp.in_vec;
                        end
`ifdef GATE_CHECK_TIMEOUT_EN
                        r_idle_cnt <= '0;
`endif
                        if (w_all_cov) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_pass     <= (w_err_next == 8'd0);
                        end
                    end
`ifdef GATE_CHECK_TIMEOUT_EN
                    else if (r_idle_cnt == c_IDLE_LAST) begin
                        r_state    <= ST_DONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_pass     <= 1'b0;
                end
            endcase
        end
    end

    assign smp.in_ready = r_in_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err_count;
    assign first_fail   = r_first_fail;

`ifdef GATE_CHECK_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
//------------------------------------------------------------------------------
// Module : tb_gate_response_checker
// Brief  : Directed self-checking bench for gate_response_checker (OR gate,
//          NUM_IN=2, TIMEOUT=16); timeout steps follow GATE_CHECK_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gate_response_checker;
    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [1:0] first_fail;
    logic       timeout;

    integer n_checks;
    integer n_fail;

    gate_response_checker_if #(.NUM_IN(2)) smp ();

    gate_response_checker #(
        .NUM_IN  (2),
        .TRUTH   (4'b1110),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .smp        (smp),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] vec, input logic out);
        smp.in_valid = 1'b1;
        smp.in_vec   = vec;
        smp.in_out   = out;
        tick();
    endtask

    task automatic idle(input int n);
        smp.in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, smp.in_ready, 0);
        check({tag, "_busy"},  busy,         0);
        check({tag, "_done"},  done,         0);
        check({tag, "_pass"},  pass,         0);
        check({tag, "_err"},   err_count,    0);
        check({tag, "_ff"},    first_fail,   0);
        check({tag, "_tmo"},   timeout,      0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        smp.in_valid = 1'b0;
        smp.in_vec   = 2'b00;
        smp.in_out   = 1'b0;
        tick();
        tick();
        check_cleared("rst");
        reset = 1'b0;
        tick();

        // Correct OR run with in_valid held
        do_start();
        check("r1_busy",  busy, 1);
        check("r1_ready", smp.in_ready, 1);
        check("r1_done0", done, 0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        send(2'b10, 1'b1);
        check("r1_done_early", done, 0);
        send(2'b11, 1'b1);
        smp.in_valid = 1'b0;
        check("r1_done", done, 1);
        check("r1_pass", pass, 1);
        check("r1_err",  err_count, 0);
        check("r1_busy_off", busy, 0);
        check("r1_ready_off", smp.in_ready, 0);
        check("r1_tmo", timeout, 0);

        // Two mismatches; DONE then ignores samples
        do_start();
        check("r2_pass_cleared", pass, 0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        send(2'b10, 1'b0);
        check("r2_err_mid", err_count, 1);
        check("r2_ff_mid", first_fail, 2'b10);
        send(2'b11, 1'b0);
        check("r2_done", done, 1);
        check("r2_err",  err_count, 2);
        check("r2_ff",   first_fail, 2'b10);
        check("r2_pass", pass, 0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        smp.in_valid = 1'b0;
        tick();
        check("r2_hold_err",  err_count, 2);
        check("r2_hold_done", done, 1);
        check("r2_hold_ff",   first_fail, 2'b10);

        // Repeats, gaps and a start ignored mid-run
        do_start();
        send(2'b01, 1'b1);
        send(2'b01, 1'b1);
        smp.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(2'b01, 1'b1);
        check("r3_done_rep", done, 0);
        idle(3);
        check("r3_gap_busy", busy, 1);
        check("r3_gap_err",  err_count, 0);
        send(2'b00, 1'b0);
        send(2'b10, 1'b1);
        check("r3_done_early", done, 0);
        send(2'b11, 1'b1);
        smp.in_valid = 1'b0;
        check("r3_done", done, 1);
        check("r3_pass", pass, 1);

        // Reset mid-run, then reset beating start
        do_start();
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        smp.in_valid = 1'b0;
        check("r4_err_pre", err_count, 1);
        check("r4_ff_pre",  first_fail, 2'b01);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_cleared("r4_rst");
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("r4_idle_busy", busy, 0);
        do_start();
        send(2'b11, 1'b1);
        send(2'b10, 1'b1);
        send(2'b01, 1'b1);
        send(2'b00, 1'b0);
        smp.in_valid = 1'b0;
        check("r4_done", done, 1);
        check("r4_pass", pass, 1);
        check("r4_err",  err_count, 0);

        // Saturation
        do_start();
        for (int k = 0; k < 255; k++) send(2'b01, 1'b0);
        check("r5_err_255", err_count, 255);
        for (int k = 0; k < 45; k++) send(2'b01, 1'b0);
        check("r5_err_sat", err_count, 255);
        check("r5_done_mid", done, 0);
        send(2'b00, 1'b0);
        send(2'b10, 1'b1);
        send(2'b11, 1'b1);
        smp.in_valid = 1'b0;
        check("r5_done", done, 1);
        check("r5_err",  err_count, 255);
        check("r5_ff",   first_fail, 2'b01);
        check("r5_pass", pass, 0);

`ifdef GATE_CHECK_TIMEOUT_EN
        // Timeout after 16 idle CHECK cycles
        do_start();
        idle(15);
        check("t1_done_15", done, 0);
        check("t1_busy_15", busy, 1);
        idle(1);
        check("t1_done", done, 1);
        check("t1_tmo",  timeout, 1);
        check("t1_pass", pass, 0);
        // Handshake on the 16th cycle wins
        do_start();
        check("t2_tmo_cleared", timeout, 0);
        idle(15);
        send(2'b00, 1'b0);
        smp.in_valid = 1'b0;
        check("t2_tmo",  timeout, 0);
        check("t2_busy", busy, 1);
        check("t2_done", done, 0);
        idle(15);
        check("t2_done_15", done, 0);
        idle(1);
        check("t2_tmo_late", timeout, 1);
        check("t2_err", err_count, 0);
`else
        // No timeout: CHECK waits indefinitely
        do_start();
        idle(40);
        check("n1_busy", busy, 1);
        check("n1_done", done, 0);
        check("n1_tmo",  timeout, 0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        send(2'b10, 1'b1);
        send(2'b11, 1'b1);
        smp.in_valid = 1'b0;
        check("n1_pass", pass, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 2, meaning the number of gate inputs per sample (range 1..4).
REQ-002 The block SHALL have parameter TRUTH, default 4'b1110 (OR), a 2**NUM_IN-bit expected truth table where bit i is the expected output for input vector i.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum idle cycles in CHECK; it is used only when the timeout feature is compiled in.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 reset  input  1  Synchronous, active-high reset.
REQ-006 start  input  1  One-cycle pulse that begins a check run.
REQ-007 in_valid  input  1  A sample is presented.
REQ-008 in_ready  output  1  The checker accepts a sample this cycle.
REQ-009 in_vec  input  NUM_IN  Gate input vector of the sample.
REQ-010 in_out  input  1  Observed gate output of the sample.
REQ-011 busy  output  1  High while in CHECK.
REQ-012 done  output  1  High while in DONE.
REQ-013 pass  output  1  High in DONE when err_count==0 and timeout==0.
REQ-014 err_count  output  8  Mismatch count, saturating.
REQ-015 first_fail  output  NUM_IN  in_vec of the first mismatching sample.
REQ-016 timeout  output  1  The run ended by timeout.

Function
REQ-017 The FSM SHALL have states IDLE, CHECK and DONE.
REQ-018 IDLE/DONE + start: next state is CHECK; err_count, first_fail, the coverage bitmap, timeout and the idle counter all clear in that same edge.
REQ-019 start while in CHECK SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in CHECK; a handshake occurs when in_valid and in_ready are both high.
REQ-021 On each handshake, expected = TRUTH[in_vec]; in_out != expected SHALL increment err_count on the next edge, holding at 255.
REQ-022 first_fail SHALL capture in_vec on the first mismatch of a run only, and remain 0 if there are no mismatches.
REQ-023 Each handshake SHALL set coverage bit in_vec; repeated vectors are checked again but add no coverage.
REQ-024 When the handshake completes coverage (all 2**NUM_IN bits set), the next state SHALL be DONE; that sample's mismatch is counted in the same edge, so done and a final err_count appear together one cycle after the handshake.
REQ-025 DONE SHALL hold, with outputs stable, until start or reset.
REQ-026 pass SHALL be 0 outside DONE.
REQ-027 in_valid while not in CHECK SHALL have no effect.

Reset
REQ-028 When reset is high, state SHALL become IDLE and all outputs SHALL be 0 (in_ready, busy, done, pass, err_count, first_fail, timeout), along with coverage and counters, including during a run in progress.
REQ-029 reset SHALL take priority over start.

Configuration
REQ-030 With GATE_CHECK_TIMEOUT_EN defined, the idle counter SHALL count cycles in CHECK without a handshake and clear on each handshake.
REQ-031 When the idle counter reaches TIMEOUT, the next state SHALL be DONE with timeout=1 (so pass=0).
REQ-032 A handshake that occurs in the same cycle as the timeout is reached SHALL win: the timeout is not flagged, and the sample is processed normally.
REQ-033 Without GATE_CHECK_TIMEOUT_EN, the timeout output SHALL be tied to 0, no counter logic SHALL exist, and CHECK waits indefinitely.

Structure
REQ-034 The shared package hack_test_pkg SHALL hold the FSM state encodings and the truth-table constants TRUTH_AND=4'b1000, TRUTH_OR=4'b1110, TRUTH_XOR=4'b0110 and TRUTH_NAND=4'b0111.
REQ-035 The sub-module gate_cov_tracker SHALL hold the coverage bitmap, with clear and set-index inputs and an all_covered output.

Verification
REQ-036 Reset then start, then feed 00/0, 01/1, 10/1, 11/1 with in_valid held high -> done one cycle after the 4th handshake, err_count=0, pass=1.
REQ-037 OR run with sample 10 observed as 0 and sample 11 observed as 0 -> err_count=2, first_fail=2'b10, pass=0.
REQ-038 Feed 01 three times, then 00, 10, 11 -> done only after 11 is accepted; in_valid gaps stall without errors.
REQ-039 Assert reset after 2 handshakes -> IDLE with all outputs 0; a new start and a full correct run -> pass=1.
REQ-040 With GATE_CHECK_TIMEOUT_EN and TIMEOUT=16, start then no in_valid -> done=1 and timeout=1 after 16 cycles in CHECK; a handshake on the 16th cycle -> no timeout.
REQ-041 Send 300 mismatching 01/0 samples before completing coverage -> err_count saturates at 255.
